stack_unit: RTL

- Hardware operand stack for the 8-bit stack-machine datapath.
- Consumes push/pop strobes from the multicycle control FSM and write data selected by stack_src in the datapath.
- Produces tos, which the control unit reads for conditional jump decisions and which feeds A/B load paths.
- Adds full/empty status and sticky overflow/underflow error flags for debug and verification.

---
 rtl/stack_pkg.sv | 20 ++
 rtl/stack_mem.sv | 64 ++++++
 rtl/stack_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// stack_pkg: shared constants and types for the operand stack.
//   STACK_WIDTH / STACK_DEPTH : default entry width and entry count
//   sp_t                      : stack pointer type (holds 0..STACK_DEPTH)
//   stack_op_e                : operation decoded from {push, pop}
package stack_pkg;

  localparam int STACK_WIDTH = 8;
  localparam int STACK_DEPTH = 8;

  typedef logic [$clog2(STACK_DEPTH+1)-1:0] sp_t;

  // Encoding matches the {push, pop} strobe pair directly.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUSH = 2'b10,
    OP_POP  = 2'b01,
    OP_REPL = 2'b11
  } stack_op_e;

endpackage

// File: rtl/stack_mem.sv
// stack_mem: DEPTH x WIDTH register array behind the operand stack.
//   clk, rst       : clock and synchronous active-high reset (clears every entry)
//   we, waddr, wdata : synchronous write port
//   sp             : current entry count, selects the read ports
//   tos            : mem[sp-1], or 0 when sp == 0 (combinational)
//   nos            : mem[sp-2], or 0 when sp < 2 (only with STACK_NOS_EN)
// Optional feature macro: STACK_NOS_EN.
module stack_mem
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter int SPW   = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [SPW-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [SPW-1:0]   sp,
  output logic [WIDTH-1:0] tos
`ifdef STACK_NOS_EN
  ,
  output logic [WIDTH-1:0] nos
`endif
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] wsel;

  // One-hot write select per entry; addresses are compared at SPW bits so
  // no out-of-range array index is ever formed.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
    assign wsel[gi] = we && (waddr == SPW'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem_reg[i] <= '0;
      end else if (wsel[i]) begin
        mem_reg[i] <= wdata;
      end
    end
  end

  // Read muxes decode sp directly; sp == 0 matches no entry and yields 0.
  always_comb begin
    tos = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp == SPW'(i + 1)) tos = mem_reg[i];
    end
  end

`ifdef STACK_NOS_EN
  always_comb begin
    nos = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (sp == SPW'(i + 2)) nos = mem_reg[i];
    end
  end
`endif

endmodule

// File: rtl/stack_unit.sv
// stack_unit: hardware operand stack for the 8-bit stack-machine datapath.
//   clk, rst   : clock and synchronous active-high reset
//   push, pop  : single-cycle operation strobes from control
//   din        : data to push (stack_src mux output)
//   err_clr    : clears the sticky error flags
//   tos, sp    : top-of-stack value and current entry count
//   empty, full: sp == 0 / sp == DEPTH
//   err_ovf    : sticky, push attempted while full
//   err_unf    : sticky, pop (or push+pop) attempted while empty
//   nos        : next-on-stack value (only with STACK_NOS_EN)
// Optional feature macro: STACK_NOS_EN.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           tos,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       empty,
  output logic                       full,
  output logic                       err_ovf,
  output logic                       err_unf
`ifdef STACK_NOS_EN
  ,
  output logic [WIDTH-1:0]           nos
`endif
);

  localparam int SPW = $clog2(DEPTH+1);

  logic [SPW-1:0] sp_reg, sp_next;
  logic           err_ovf_reg, err_unf_reg;
  logic           ovf_set, unf_set;
  logic           we;
  logic [SPW-1:0] waddr;
  stack_op_e      op;

  assign op    = stack_op_e'({push, pop});
  assign empty = (sp_reg == '0);
  assign full  = (sp_reg == SPW'(DEPTH));

  always_comb begin
    sp_next = sp_reg;
    we      = 1'b0;
    waddr   = sp_reg;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        if (!full) begin
          we      = 1'b1;
          sp_next = sp_reg + SPW'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        // Vacated entry keeps stale data; tos never exposes it.
        if (!empty) sp_next = sp_reg - SPW'(1);
        else        unf_set = 1'b1;
      end
      OP_REPL: begin
        if (!empty) begin
          we    = 1'b1;
          waddr = sp_reg - SPW'(1);
        end else begin
          // Nothing to pop: the push still lands in entry 0 (waddr = sp = 0).
          we      = 1'b1;
          sp_next = SPW'(1);
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_reg      <= '0;
      err_ovf_reg <= 1'b0;
      err_unf_reg <= 1'b0;
    end else begin
      sp_reg      <= sp_next;
      // A new error outranks a simultaneous clear.
      err_ovf_reg <= ovf_set | (err_ovf_reg & ~err_clr);
      err_unf_reg <= unf_set | (err_unf_reg & ~err_clr);
    end
  end

  assign sp      = sp_reg;
  assign err_ovf = err_ovf_reg;
  assign err_unf = err_unf_reg;

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .SPW   (SPW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (din),
    .sp    (sp_reg),
    .tos   (tos)
`ifdef STACK_NOS_EN
    ,
    .nos   (nos)
`endif
  );

endmodule
